// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lc3_mem_pkg
// Description : Shared types and constants for the LC3 memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    // Per-port access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_port_state_t;

    typedef logic [15:0] lc3_word_t;

    // Start of user program space; default lower bound of writable memory
    localparam lc3_word_t BASE_ADDR = 16'h3000;

endpackage
`default_nettype wire

// File: rtl/lc3_mem_port_fsm.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_port_fsm
// Description : One memory port sequencer. LAT=0 passes the request straight
//               through; LAT>0 latches the request and completes it LAT
//               cycles later, generating read-capture and write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_port_fsm
    import lc3_mem_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    input  logic [15:0] i_din,
    output logic        o_complete,
    output logic [15:0] o_addr,
    output logic        o_rd_load,
    output logic        o_wr_en,
    output logic [15:0] o_wr_data
);

    generate
        if (LAT == 0) begin : g_comb
            // Clock and reset are not needed when the port is purely combinational
            logic w_unused_clk;
            assign w_unused_clk = &{1'b0, clk, rst};

            // Zero latency: complete, address and write strobe follow the request directly
            always_comb begin
                o_complete = i_req;
                o_addr     = i_addr;
                o_rd_load  = 1'b0;
                o_wr_en    = i_req & ~i_rd;
                o_wr_data  = i_din;
            end
        end else begin : g_fsm
            localparam int c_CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

            mem_port_state_t    r_state, w_state_nxt;
            logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
            logic [15:0]        r_addr, r_din;
            logic               r_rd;
            logic               w_latch;

            // State, counter and latched request registers
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_addr  <= '0;
                    r_din   <= '0;
                    r_rd    <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    if (w_latch) begin
                        r_addr <= i_addr;
                        r_din  <= i_din;
                        r_rd   <= i_rd;
                    end
                end
            end

            // Next state and strobes; the read is captured on the edge entering DONE
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_latch     = 1'b0;
                o_complete  = 1'b0;
                o_rd_load   = 1'b0;
                o_wr_en     = 1'b0;
                o_addr      = r_addr;
                o_wr_data   = r_din;
                case (r_state)
                    IDLE: begin
                        o_addr = i_addr;
                        if (i_req) begin
                            w_latch = 1'b1;
                            if (LAT == 1) begin
                                w_state_nxt = DONE;
                                o_rd_load   = i_rd;
                            end else begin
                                w_state_nxt = WAIT;
                                w_cnt_nxt   = c_CNT_W'(LAT - 1);
                            end
                        end
                    end
                    WAIT: begin
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(1)) begin
                            w_state_nxt = DONE;
                            o_rd_load   = r_rd;
                        end
                    end
                    DONE: begin
                        o_complete  = 1'b1;
                        o_wr_en     = ~r_rd;
                        w_state_nxt = IDLE;
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_responder
// Description : Unified 16-bit word memory serving the LC3 instruction-fetch
//               and data ports, each with programmable completion latency,
//               plus a backdoor preload port.
// Options     : LC3_MEM_PROT_EN - data writes below PROT_LIMIT are dropped
//               and flagged on the sticky prot_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int        ADDR_W     = 16,
    parameter int        INSTR_LAT  = 0,
    parameter int        DATA_LAT   = 0,
    parameter lc3_word_t PROT_LIMIT = BASE_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        data_req,
    input  logic [15:0] Data_addr,
    input  logic        Data_rd,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic        prot_err
);

    localparam int c_DEPTH = 1 << ADDR_W;

    lc3_word_t r_mem [0:c_DEPTH-1];

    logic              w_ins_complete, w_ins_rd_load, w_ins_wr_en;
    logic [15:0]       w_ins_addr, w_ins_wr_data;
    logic              w_dat_complete, w_dat_rd_load, w_dat_wr_en;
    logic [15:0]       w_dat_addr, w_dat_wr_data;
    logic [ADDR_W-1:0] w_ins_idx, w_dat_idx, w_load_idx;
    logic              w_wr_allowed, w_wr_commit;
    logic              w_unused_sigs;

    lc3_mem_port_fsm #(.LAT(INSTR_LAT)) u_instr_port (
        .clk        (clock),
        .rst        (reset),
        .i_req      (instrmem_rd),
        .i_addr     (pc),
        .i_rd       (1'b1),
        .i_din      (16'h0000),
        .o_complete (w_ins_complete),
        .o_addr     (w_ins_addr),
        .o_rd_load  (w_ins_rd_load),
        .o_wr_en    (w_ins_wr_en),
        .o_wr_data  (w_ins_wr_data)
    );

    lc3_mem_port_fsm #(.LAT(DATA_LAT)) u_data_port (
        .clk        (clock),
        .rst        (reset),
        .i_req      (data_req),
        .i_addr     (Data_addr),
        .i_rd       (Data_rd),
        .i_din      (Data_din),
        .o_complete (w_dat_complete),
        .o_addr     (w_dat_addr),
        .o_rd_load  (w_dat_rd_load),
        .o_wr_en    (w_dat_wr_en),
        .o_wr_data  (w_dat_wr_data)
    );

    // The fetch port never writes; read-capture strobes are idle on zero-latency ports
    assign w_unused_sigs = &{1'b0, w_ins_wr_en, w_ins_wr_data, w_ins_rd_load, w_dat_rd_load};

    // Upper address bits are dropped, so addresses alias modulo the array depth
    assign w_ins_idx  = w_ins_addr[ADDR_W-1:0];
    assign w_dat_idx  = w_dat_addr[ADDR_W-1:0];
    assign w_load_idx = load_addr[ADDR_W-1:0];

    assign complete_instr = w_ins_complete;
    assign complete_data  = w_dat_complete;

`ifdef LC3_MEM_PROT_EN
    logic r_prot_err;
    logic w_violation;

    assign w_wr_allowed = (w_dat_addr >= PROT_LIMIT);
    assign w_violation  = w_dat_wr_en & ~w_wr_allowed & ~reset;

    // Sticky violation flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prot_err <= 1'b0;
        end else if (w_violation) begin
            r_prot_err <= 1'b1;
        end
    end

    // The live term makes the flag visible in the offending completion cycle
    assign prot_err = r_prot_err | w_violation;
`else
    assign w_wr_allowed = 1'b1;
    assign prot_err     = 1'b0;
`endif

    // A write in flight when reset arrives is discarded
    assign w_wr_commit = w_dat_wr_en & w_wr_allowed & ~reset;

    // Array writes; the later backdoor load wins a same-address collision
    always_ff @(posedge clock) begin
        if (w_wr_commit) begin
            r_mem[w_dat_idx] <= w_dat_wr_data;
        end
        if (load_en) begin
            r_mem[w_load_idx] <= load_data;
        end
    end

    generate
        if (INSTR_LAT == 0) begin : g_instr_async
            assign Instr_dout = r_mem[w_ins_idx];
        end else begin : g_instr_reg
            lc3_word_t r_instr_dout;
            // Fetch data captured on entry to DONE, held until the next fetch
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_instr_dout <= '0;
                end else if (w_ins_rd_load) begin
                    r_instr_dout <= r_mem[w_ins_idx];
                end
            end
            assign Instr_dout = r_instr_dout;
        end

        if (DATA_LAT == 0) begin : g_data_async
            assign Data_dout = r_mem[w_dat_idx];
        end else begin : g_data_reg
            lc3_word_t r_data_dout;
            // Read data captured on entry to DONE; writes leave it unchanged
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_data_dout <= '0;
                end else if (w_dat_rd_load) begin
                    r_data_dout <= r_mem[w_dat_idx];
                end
            end
            assign Data_dout = r_data_dout;
        end
    endgenerate

endmodule
`default_nettype wire
